// File: rtl/alu_issue_buf_if.sv
// alu_issue_buf_if: request/response bundle between decode, the issue buffer and the ALU.
//   Upstream side : in_valid, in_ready, in_a, in_b, in_cin, in_inv_a, in_inv_b, in_sign, in_oper, flush
//   Downstream side: out_valid, out_ready, out_a, out_b, out_cin, out_inv_a, out_inv_b, out_sign, out_oper
//   Status        : occ (number of buffered requests)
//   modport slave  - the buffer itself
//   modport master - the environment driving/consuming the buffer
interface alu_issue_buf_if #(
  parameter int unsigned OPERAND_WIDTH  = 16,
  parameter int unsigned NUM_OPERATIONS = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [OPERAND_WIDTH-1:0]  in_a;
  logic [OPERAND_WIDTH-1:0]  in_b;
  logic                      in_cin;
  logic                      in_inv_a;
  logic                      in_inv_b;
  logic                      in_sign;
  logic [NUM_OPERATIONS-1:0] in_oper;
  logic                      flush;

  logic                      out_valid;
  logic                      out_ready;
  logic [OPERAND_WIDTH-1:0]  out_a;
  logic [OPERAND_WIDTH-1:0]  out_b;
  logic                      out_cin;
  logic                      out_inv_a;
  logic                      out_inv_b;
  logic                      out_sign;
  logic [NUM_OPERATIONS-1:0] out_oper;

  logic [1:0]                occ;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_inv_a, in_inv_b, in_sign, in_oper, flush, out_ready,
    output in_ready, out_valid, out_a, out_b, out_cin, out_inv_a, out_inv_b, out_sign, out_oper, occ
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, in_inv_a, in_inv_b, in_sign, in_oper, flush, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_cin, out_inv_a, out_inv_b, out_sign, out_oper, occ
  );
endinterface

// File: rtl/alu_issue_buf.sv
// alu_issue_buf: registered issue buffer between decode and the ALU.
//   Accepts one request bundle per cycle, presents it to the ALU one cycle later,
//   keeps requests in order and holds out_* stable while the ALU stalls.
//   Ports:
//     clk - clock, rising edge
//     rst - asynchronous active-high reset
//     bus - alu_issue_buf_if.slave (in_* request, out_* request, flush, occ)
//   Configuration macro ALU_ISSUE_SKID_EN:
//     defined   - two entries (head + skid), in_ready registered
//     undefined - single entry, in_ready = !out_valid || out_ready
module alu_issue_buf #(
  parameter int unsigned OPERAND_WIDTH  = 16,
  parameter int unsigned NUM_OPERATIONS = 3
) (
  input  logic            clk,
  input  logic            rst,
  alu_issue_buf_if.slave  bus
);

  // Payload layout: {a, b, cin, inv_a, inv_b, sign, oper}
  localparam int unsigned PLD_W = 2 * OPERAND_WIDTH + 4 + NUM_OPERATIONS;

  // State encoding equals the occupancy count
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
`ifdef ALU_ISSUE_SKID_EN
  localparam logic [1:0] ST_TWO   = 2'd2;
`endif

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PLD_W-1:0] r_head;
  logic [PLD_W-1:0] w_head_nxt;
  logic             r_out_valid;
  logic [PLD_W-1:0] w_in_pld;
  logic             w_in_ready;
  logic             w_in_xfer;
  logic             w_out_xfer;

`ifdef ALU_ISSUE_SKID_EN
  logic [PLD_W-1:0] r_skid;
  logic [PLD_W-1:0] w_skid_nxt;
  logic             r_in_ready;

  assign w_in_ready = r_in_ready;
`else
  // Single entry: accept whenever the entry is free or leaving this cycle
  assign w_in_ready = !r_out_valid || bus.out_ready;
`endif

  assign w_in_pld   = {bus.in_a, bus.in_b, bus.in_cin, bus.in_inv_a,
                       bus.in_inv_b, bus.in_sign, bus.in_oper};
  assign w_in_xfer  = bus.in_valid && w_in_ready;
  assign w_out_xfer = r_out_valid && bus.out_ready;

  // Next-state and payload movement; flush overrides every transfer
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
`ifdef ALU_ISSUE_SKID_EN
    w_skid_nxt  = r_skid;
`endif
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = w_in_pld;
        end
      end
      ST_ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_head_nxt = w_in_pld;
        end
`ifdef ALU_ISSUE_SKID_EN
        else if (w_in_xfer) begin
          w_state_nxt = ST_TWO;
          w_skid_nxt  = w_in_pld;
        end
`endif
        else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
          w_head_nxt  = '0;
        end
      end
`ifdef ALU_ISSUE_SKID_EN
      ST_TWO: begin
        if (w_out_xfer) begin
          w_state_nxt = ST_ONE;
          w_head_nxt  = r_skid;
          w_skid_nxt  = '0;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_EMPTY;
        w_head_nxt  = '0;
      end
    endcase
    if (bus.flush) begin
      w_state_nxt = ST_EMPTY;
      w_head_nxt  = '0;
`ifdef ALU_ISSUE_SKID_EN
      w_skid_nxt  = '0;
`endif
    end
  end

  // State, payload and registered handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_head      <= '0;
      r_out_valid <= 1'b0;
`ifdef ALU_ISSUE_SKID_EN
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_head      <= w_head_nxt;
      r_out_valid <= (w_state_nxt != ST_EMPTY);
`ifdef ALU_ISSUE_SKID_EN
      r_skid      <= w_skid_nxt;
      r_in_ready  <= (w_state_nxt != ST_TWO);
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.occ       = r_state;
  assign {bus.out_a, bus.out_b, bus.out_cin, bus.out_inv_a,
          bus.out_inv_b, bus.out_sign, bus.out_oper} = r_head;

endmodule

// File: doc/alu_issue_buf.md
ALU_ISSUE_BUF -- requirements
Module: alu_issue_buf

Interface
REQ-001 Parameter OPERAND_WIDTH, default 16: width of each ALU operand.
REQ-002 Parameter NUM_OPERATIONS, default 3: width of the ALU operation code.
REQ-003 The design SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  upstream (decode) presents a valid ALU request.
REQ-007 in_ready  output  1  buffer can accept a request this cycle.
REQ-008 in_a, in_b  input  OPERAND_WIDTH each  operands.
REQ-009 in_cin, in_inv_a, in_inv_b, in_sign  input  1 each  carry-in, invert-A, invert-B, signed-op controls.
REQ-010 in_oper  input  NUM_OPERATIONS  operation code.
REQ-011 flush  input  1  synchronous discard of all buffered requests.
REQ-012 out_valid  output  1  request presented to the ALU is valid.
REQ-013 out_ready  input  1  downstream ALU/execute stage consumes the request this cycle.
REQ-014 out_a, out_b, out_cin, out_oper, out_inv_a, out_inv_b, out_sign  output  same widths as inputs  registered request driving ALU inputs.
REQ-015 occ  output  2  current number of buffered requests (0..2).

Function
REQ-016 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-017 Request payload (operands, operation code, four control bits) SHALL travel as one bundle, unmodified.
REQ-018 Latency: a request accepted in cycle N SHALL first appear on out_* with out_valid=1 in cycle N+1; no combinational in-to-out path.
REQ-019 Requests SHALL leave in acceptance order; none duplicated or dropped except by flush/reset.
REQ-020 While out_valid=1 and out_ready=0, out_* SHALL hold stable.
REQ-021 States: EMPTY (occ=0), ONE (occ=1, head valid), TWO (occ=2, head+skid valid).
REQ-022 EMPTY + input transfer -> ONE, payload into head.
REQ-023 ONE + input and output transfer -> ONE, new payload into head.
REQ-024 ONE + input only -> TWO, payload into skid; ONE + output only -> EMPTY.
REQ-025 TWO + output transfer -> ONE, skid moves to head; TWO with no output transfer -> TWO.
REQ-026 in_ready SHALL be a registered signal, 1 in EMPTY and ONE, 0 in TWO; out_valid SHALL be 1 in ONE and TWO.
REQ-027 flush=1 SHALL force EMPTY next cycle, overriding any same-cycle input or output transfer; an input accepted in the flush cycle is discarded.
REQ-028 out_* payload SHALL be zero whenever occ=0.

Reset
REQ-029 rst=1 SHALL asynchronously force EMPTY: occ=0, out_valid=0, in_ready=1, all out_* payload=0.
REQ-030 Reset mid-operation SHALL discard all buffered requests; the first cycle after deassertion behaves as EMPTY.

Configuration
REQ-031 Macro ALU_ISSUE_SKID_EN SHALL select buffering depth.
REQ-032 With ALU_ISSUE_SKID_EN defined: two-entry behaviour of REQ-021..REQ-026.
REQ-033 Without it: single entry only (states EMPTY, ONE); in_ready = !out_valid || out_ready (combinational); ONE + input only is not possible; occ never exceeds 1; all other requirements hold.

Verification
REQ-034 Reset, then in_valid=1, in_a=16'h0005, in_b=16'h0003, in_oper=3'b100, out_ready=1 -> next cycle out_valid=1, out_a=16'h0005, out_b=16'h0003, out_oper=3'b100, occ=1.
REQ-035 (SKID_EN) Push A=16'h1111, B=16'h2222 on consecutive cycles with out_ready=0 -> occ=2, in_ready=0, out_a=16'h1111 stable; raise out_ready -> 16'h1111 then 16'h2222 emitted in order.
REQ-036 Continuous in_valid=1, out_ready=1, 8 requests with in_a=0..7 -> out_a=0..7 on consecutive cycles, occ=1 throughout, no bubbles.
REQ-037 occ=2, assert flush with in_valid=1 same cycle -> next cycle occ=0, out_valid=0, out_*=0, in_ready=1.
REQ-038 occ=1, assert rst asynchronously mid-cycle -> out_valid=0 and occ=0 immediately, before the next clock edge.
REQ-039 Without ALU_ISSUE_SKID_EN, out_valid=1, out_ready=0 -> in_ready=0; out_ready=1 with in_valid=1 -> in_ready=1, new payload on out_* next cycle.
